divu_unit: RTL and testbench
============================

// Module: divu_unit
// PURPOSE
//  Iterative restoring integer divider for the EX stage. It is the inverse
//  of the MULTU path: MULTU forms {Hi,Lo} = A*B, while this block forms
//  Lo = A/B and Hi = A%B, for both DIVU and DIV.
//  - Multi-cycle, one quotient bit per clock.
//  - Start/busy/done handshake toward the ALU control and the Hi/Lo register.
//  - While busy is high, the hazard unit stalls the pipeline.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width
//  CNTW   6   iteration counter width; must satisfy 2**CNTW > WIDTH
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous reset, active low
//  start        in   1      request a divide; sampled only in IDLE or DONE
//  signed_op    in   1      1 = DIV (two's complement), 0 = DIVU
//  dataA        in   WIDTH  dividend, captured on an accepted start
//  dataB        in   WIDTH  divisor, captured on an accepted start
//  busy         out  1      high while in CALC or FIX
//  done         out  1      one-cycle pulse; results are valid from this cycle on
//  quotient     out  WIDTH  written to Lo
//  remainder    out  WIDTH  written to Hi
//  div_by_zero  out  1      set with done when the captured dataB == 0
// BEHAVIOUR
//  Reset (rst=0 at an edge):
//   - state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0.
//   - Reset dominates everything. Mid-operation it aborts the divide, and no
//     done is produced.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   - IDLE / DONE: start=1 captures the operands and clears div_by_zero.
//     - If dataB==0: go to DONE. Then quotient = all ones, remainder = dataA,
//       div_by_zero = 1.
//     - Otherwise: go to CALC and load the magnitudes:
//       |A| and |B| when signed_op=1, raw values when signed_op=0.
//       Record sign_q = A[MSB]^B[MSB] and sign_r = A[MSB] (both 0 for DIVU).
//       Clear the partial remainder and the counter.
//   - CALC, per cycle:
//       {R,Q} <<= 1; trial = R - |B| (WIDTH+1 bits).
//       If trial >= 0: R = trial[WIDTH-1:0] and Q[0] = 1; else Q[0] = 0.
//       The counter increments; after exactly WIDTH cycles go to FIX.
//   - FIX: quotient = sign_q ? -Q : Q; remainder = sign_r ? -R : R. Go to DONE.
//   - DONE: done=1 for this cycle only. Outputs hold until the next accepted
//     start. With no start, go to IDLE.
//  Latency (start high in cycle N):
//   - Normal: done in cycle N+WIDTH+2 (34 for WIDTH=32).
//   - Divide by zero: done in cycle N+1.
//  Handshake:
//   - start while busy=1 is ignored.
//   - start in the DONE cycle is accepted, giving back-to-back divides.
//   - Operands are not re-sampled after capture.
//  Arithmetic:
//   - Signed division truncates toward zero; the remainder takes the sign of
//     the dividend (MIPS semantics).
//   - Overflow case 0x80000000 / 0xFFFFFFFF (DIV) gives quotient 0x80000000,
//     remainder 0. This needs no special path.
//   - Magnitude of 0x80000000 is 0x80000000, interpreted as unsigned.
//  Stability: quotient and remainder change only in FIX, in the DONE entry on
//   divide by zero, and at reset. They are stable at all other times.
// STRUCTURE
//  Shared package alu_pkg:
//   - state encoding (IDLE, CALC, FIX, DONE as 2-bit localparams)
//   - funct codes DIV = 6'b011010 and DIVU = 6'b011011, used by ALUControl
//  Sub-module div_step (combinational, WIDTH-parameterised):
//   - in:  R, Q, B
//   - out: next R and Q for one restoring iteration
//  Top level holds the FSM, counter, sign flags and output registers.
// TESTING
//  1. DIVU 100/7, start held 1 cycle -> done at N+34, quotient=14, remainder=2,
//     div_by_zero=0, busy high for cycles N+1..N+33.
//  2. DIV -7/2 (0xFFFFFFF9, 2) -> quotient=0xFFFFFFFD (-3),
//     remainder=0xFFFFFFFF (-1); DIV 7/-2 -> quotient=-3, remainder=1.
//  3. DIVU 5/0 -> done at N+1, div_by_zero=1, quotient=0xFFFFFFFF,
//     remainder=5; busy never asserts.
//  4. DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0;
//     DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
//  5. start pulsed at N+5 during busy -> ignored, first result unchanged.
//     start in the DONE cycle with 9/3 -> second done 34 cycles later,
//     quotient=3.
//  6. rst=0 at cycle N+10 mid-divide -> next cycle all outputs 0, state IDLE,
//     no done pulse. A following 8/2 -> quotient=4.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Definitions shared between the ALU control and the iterative
//               divider: divider state encoding and the DIV/DIVU funct codes.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Divider FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // R-type funct codes decoded by ALUControl to select the divider
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  // True for either divide funct code
  function automatic logic is_div_funct(input logic [5:0] funct);
    return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/divu_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : divu_unit_if
// Description : Start/busy/done handshake and operand/result bus between the
//               ALU control (master) and the divider (slave).
//   start, signed_op, dataA, dataB : master -> slave
//   busy, done, quotient, remainder, div_by_zero : slave -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface divu_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dataA, dataB,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dataA, dataB,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/divu_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module      : divu_unit_div_step
// Description : One combinational restoring-division iteration. Shifts the
//               {R,Q} pair left by one, trial-subtracts the divisor from R and
//               keeps the difference when it is non-negative.
//   r_i, q_i, b_i : partial remainder, working quotient/dividend, divisor
//   r_o, q_o      : values after the iteration
// Revision    : 1.0 - initial release
// ============================================================================
module divu_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // R < B always holds, so the shifted value is < 2B and the trial difference
  // lies in [-B, B-1]: WIDTH+1 bits are enough and the MSB is the sign.
  always_comb begin
    shifted = {r_i, q_i[WIDTH-1]};
    trial   = shifted - {1'b0, b_i};
    if (!trial[WIDTH]) begin
      r_o = trial[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end else begin
      r_o = shifted[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/divu_unit.sv
`default_nettype none
// ============================================================================
// Module      : divu_unit
// Description : Iterative restoring divider for DIV/DIVU, one quotient bit per
//               clock. Produces Lo = A/B (quotient) and Hi = A%B (remainder).
//   clk  : rising-edge clock
//   rst  : synchronous reset, active low
//   bus  : divu_unit_if.slave (start/signed_op/dataA/dataB in,
//          busy/done/quotient/remainder/div_by_zero out)
//   CNTW must satisfy 2**CNTW > WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module divu_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic      clk,
  input  logic      rst,
  divu_unit_if.slave bus
);
  import alu_pkg::*;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r_q;          // partial remainder magnitude
  logic [WIDTH-1:0] wq_q;         // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] b_q;          // divisor magnitude
  logic [CNTW-1:0]  cnt_q;
  logic             qsign_q;
  logic             rsign_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             accept;
  logic             b_zero;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             busy_o;
  logic             done_o;

  // start is only honoured when no divide is in flight
  assign accept    = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign b_zero    = (bus.dataB == '0);
  assign last_iter = (cnt_q == CNTW'(WIDTH - 1));

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign a_mag = (bus.signed_op && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
  assign b_mag = (bus.signed_op && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;

  divu_unit_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i (r_q),
    .q_i (wq_q),
    .b_i (b_q),
    .r_o (r_next),
    .q_o (q_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = b_zero ? ST_DONE : ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (last_iter) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o = (state_q == ST_CALC) || (state_q == ST_FIX);
    done_o = (state_q == ST_DONE);
  end

  // Datapath: operand capture, iteration, sign fix-up
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q         <= '0;
      wq_q        <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      dbz_q <= b_zero;
      if (b_zero) begin
        quotient_q  <= '1;
        remainder_q <= bus.dataA;
      end else begin
        r_q     <= '0;
        wq_q    <= a_mag;
        b_q     <= b_mag;
        cnt_q   <= '0;
        qsign_q <= bus.signed_op && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
        rsign_q <= bus.signed_op && bus.dataA[WIDTH-1];
      end
    end else if (state_q == ST_CALC) begin
      r_q   <= r_next;
      wq_q  <= q_next;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == ST_FIX) begin
      // Truncation toward zero; remainder follows the dividend's sign
      quotient_q  <= qsign_q ? -wq_q : wq_q;
      remainder_q <= rsign_q ? -r_q  : r_q;
    end
  end

  assign bus.busy        = busy_o;
  assign bus.done        = done_o;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_divu_unit.sv
`timescale 1ns/1ps
module tb_divu_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  divu_unit_if #(.WIDTH(W)) bus ();

  divu_unit #(.WIDTH(W), .CNTW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  typedef struct {
    logic        sop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic, no overflow possible
  function automatic void model(input logic sop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
      return;
    end
    sa = sop ? {{32{a[31]}}, a} : {32'b0, a};
    sb = sop ? {{32{b[31]}}, b} : {32'b0, b};
    lq = sa / sb;
    lr = sa % sb;
    q = lq[31:0]; r = lr[31:0]; dz = 1'b0;
  endfunction

  // Call #1 after a rising edge with the DUT idle or in DONE.
  task automatic run_div(input logic sop, input logic [31:0] a, input logic [31:0] b,
                         input int glitch_at,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output int busy_n, output bit stable);
    bus.start = 1'b1; bus.signed_op = sop; bus.dataA = a; bus.dataB = b;
    lat = 0; busy_n = 0; stable = 1'b1;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1 || lat == glitch_at + 1) bus.start = 1'b0;
      if (glitch_at > 0 && lat == glitch_at) begin
        bus.start = 1'b1; bus.signed_op = ~sop; bus.dataA = 32'd9; bus.dataB = 32'd3;
      end
      if (bus.busy) busy_n++;
      if (bus.done) break;
      if (bus.quotient !== last_q || bus.remainder !== last_r) stable = 1'b0;
      if (lat >= 100) break;
    end
    q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero;
  endtask

  task automatic do_vec(input string tag, input logic sop, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int glitch_at);
    logic [31:0] q, r;
    logic dz;
    int lat, busy_n;
    bit stable;
    run_div(sop, a, b, glitch_at, q, r, dz, lat, busy_n, stable);
    chk({tag, " quotient"},  q, eq);
    chk({tag, " remainder"}, r, er);
    chk({tag, " div_by_zero"}, dz, edz);
    chk({tag, " latency"}, lat, edz ? 1 : W + 2);
    chk({tag, " busy cycles"}, busy_n, edz ? 0 : W + 1);
    chk({tag, " outputs stable"}, stable, 1'b1);
    last_q = eq; last_r = er;
  endtask

  initial begin
    logic [31:0] mq, mr, ra, rb;
    logic mdz, rs;
    int done_n;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[6]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
    vecs[8]  = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
    vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    vecs[11] = '{1'b0, 32'd7,          32'd8,          32'd0,          32'd7,          1'b0};

    bus.start = 1'b0; bus.signed_op = 1'b0; bus.dataA = '0; bus.dataB = '0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset quotient", bus.quotient, 32'd0);
    chk("reset remainder", bus.remainder, 32'd0);
    chk("reset div_by_zero", bus.div_by_zero, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table, issued back-to-back from each DONE cycle
    for (int i = 0; i < 12; i++) begin
      do_vec($sformatf("vec%0d", i), vecs[i].sop, vecs[i].a, vecs[i].b,
             vecs[i].q, vecs[i].r, vecs[i].dz, 0);
    end

    // done is a single-cycle pulse; results hold afterwards
    @(posedge clk); #1;
    chk("done pulse width", bus.done, 1'b0);
    chk("held quotient", bus.quotient, last_q);
    chk("held remainder", bus.remainder, last_r);

    // start during busy ignored, then back-to-back start in DONE
    do_vec("ignored start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 5);
    do_vec("back-to-back", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);

    // Reset mid-divide aborts without a done pulse
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dataA = 32'd100; bus.dataB = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (k == 10) begin
        chk("busy before abort", bus.busy, 1'b1);
        rst = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("abort busy", bus.busy, 1'b0);
    chk("abort done", bus.done, 1'b0);
    chk("abort quotient", bus.quotient, 32'd0);
    chk("abort remainder", bus.remainder, 32'd0);
    chk("abort div_by_zero", bus.div_by_zero, 1'b0);
    rst = 1'b1;
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) done_n++;
    end
    chk("no done after abort", done_n, 0);
    last_q = '0; last_r = '0;
    do_vec("after abort", 1'b0, 32'd8, 32'd2, 32'd4, 32'd0, 1'b0, 0);

    // Randomized against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      model(rs, ra, rb, mq, mr, mdz);
      do_vec($sformatf("rand%0d a=%h b=%h s=%0d", i, ra, rb, rs), rs, ra, rb, mq, mr, mdz, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
